control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Registered, multi-cycle successor to the combinational control core. Accepts one decoded instruction ID at a time and sequences instructions that need more than one cycle: handshaked I/O (INPUT/OUTPUT/PAUSE) on a parametrised number of I/O channels, burst stack transfers (PUSHN/POPN) and HALT. Sits between the instruction decoder and the datapath control decode. Its `enable` output gates PC advance and register writeback.

Parameters:
- ID_WIDTH, 7, width of instruction ID.
- COUNT_WIDTH, 5, width of the PUSHN/POPN word count.
- IO_CHANNELS, 2, number of independent I/O confirmation channels.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous button input (minimum 2).

Ports:
- clock in 1: system clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- instr_valid in 1: ID/operand fields valid; sampled only when busy=0.
- ID in ID_WIDTH: instruction ID, same numbering as the control core.
- operand_count in COUNT_WIDTH: word count for PUSHN/POPN.
- io_channel in $clog2(IO_CHANNELS): channel for INPUT/OUTPUT.
- confirmation in IO_CHANNELS: per-channel confirm buttons, asynchronous.
- continue_button in 1: PAUSE release button, asynchronous.
- enable out 1: one-cycle pulse when the instruction completes.
- busy out 1: sequencer not in IDLE.
- is_input out 1: INPUT or PAUSE wait in progress.
- is_output out 1: OUTPUT or PAUSE wait in progress.
- io_select out IO_CHANNELS: one-hot active channel during an I/O wait.
- mem_write out 1: memory write strobe for PUSHN burst beats.
- mem_read out 1: memory read strobe for POPN burst beats.
- step_index out COUNT_WIDTH: current burst beat, 0..N-1.
- halted out 1: sequencer in HALTED.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0. Synchronizers cleared. The "armed" flags of all channels are set to 1. No partial completion is reported.
- States: IDLE, EXEC, IO_WAIT, IO_RELEASE, BURST, HALTED.
- IDLE: when instr_valid=1, latch ID, count and channel, then select the next state by ID:
  - 69 (OUTPUT), 71 (INPUT), 70 (PAUSE) → IO_WAIT.
  - 77 (PUSHN), 78 (POPN) with count>0 → BURST.
  - 77/78 with count=0 → EXEC.
  - 75 (HALT) → HALTED.
  - All other IDs → EXEC.
  - instr_valid is ignored while busy=1.
- EXEC: enable=1 for exactly one cycle, then → IDLE. Single-cycle latency: instr_valid at edge t gives enable high in cycle t+1.
- IO_WAIT: outputs by ID:
  - OUTPUT: is_output=1.
  - INPUT: is_input=1.
  - PAUSE: both 1.
  - io_select = onehot(channel); for PAUSE io_select=0.
  - Wait for a synchronized rising edge of confirmation[channel] (continue_button for PAUSE) while that channel is armed. On the edge: enable=1 for one cycle, disarm the channel, → IO_RELEASE.
- IO_RELEASE: I/O flags drop. Stay until the synchronized button reads 0, then re-arm → IDLE. A button held down therefore completes at most one I/O instruction.
- io_channel ≥ IO_CHANNELS: treated as channel 0.
- BURST: runs N=count beats, one per cycle.
  - step_index counts 0..N-1.
  - mem_write=1 on every beat for PUSHN; mem_read=1 on every beat for POPN.
  - enable=1 only on beat N-1, then → IDLE.
  - count = 2^COUNT_WIDTH-1 is legal; step_index never wraps.
- HALTED: halted=1, busy=1, enable=0. Only reset exits.
- Button edge detection is taken from the last two synchronizer stages. Confirmation edges on non-selected channels are ignored and do not disarm them.
- Reset arriving mid-BURST aborts with no further strobes; the beats already issued are not retracted.

Test Plan:
- Reset, then ID=4 with instr_valid → enable high exactly in the next cycle, busy low the cycle after.
- ID=77, count=3 → mem_write high for 3 consecutive cycles, step_index 0,1,2, enable only with step_index=2. ID=78, count=0 → single enable, no mem_read.
- ID=71, channel=1: pulse confirmation[0] → no completion. Pulse confirmation[1] → after SYNC_STAGES+1 cycles enable pulses once and is_input drops.
- ID=69 with confirmation[0] held high throughout: first OUTPUT completes; second OUTPUT does not complete until the button is released and pressed again.
- ID=75 → halted=1; instr_valid with ID=4 is ignored for 20 cycles; reset clears halted asynchronously.
- ID=77, count=8: assert reset at beat 4 → all outputs 0 immediately, step_index=0, state IDLE after reset releases.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Registered multi-cycle sequencer between the instruction decoder and the
//   datapath control decode. Takes one decoded instruction at a time and
//   sequences handshaked I/O (INPUT/OUTPUT/PAUSE), burst stack transfers
//   (PUSHN/POPN) and HALT. `enable` pulses once when an instruction completes
//   and gates PC advance / register writeback.
//
// Handshake: instr_valid is sampled on a rising clock edge only while busy=0;
//   a sampled instruction is accepted unconditionally and busy rises in the
//   next cycle. While busy=1, instr_valid and the operand fields are ignored.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   instr_valid, ID       instruction strobe and instruction ID
//   operand_count         PUSHN/POPN word count
//   io_channel            channel for INPUT/OUTPUT (out of range -> channel 0)
//   confirmation          per-channel asynchronous confirm buttons
//   continue_button       asynchronous PAUSE release button
//   enable                one-cycle completion pulse
//   busy                  sequencer not idle
//   is_input, is_output   I/O wait in progress (both for PAUSE)
//   io_select             one-hot channel of the current I/O wait
//   mem_write, mem_read   per-beat strobes for PUSHN / POPN bursts
//   step_index            current burst beat
//   halted                sequencer halted (only reset exits)
//   state_dbg             current FSM state for debug/checkers
module control_sequencer #(
  parameter int ID_WIDTH    = 7,
  parameter int COUNT_WIDTH = 5,
  parameter int IO_CHANNELS = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           instr_valid,
  input  logic [ID_WIDTH-1:0]            ID,
  input  logic [COUNT_WIDTH-1:0]         operand_count,
  input  logic [$clog2(IO_CHANNELS)-1:0] io_channel,
  input  logic [IO_CHANNELS-1:0]         confirmation,
  input  logic                           continue_button,
  output logic                           enable,
  output logic                           busy,
  output logic                           is_input,
  output logic                           is_output,
  output logic [IO_CHANNELS-1:0]         io_select,
  output logic                           mem_write,
  output logic                           mem_read,
  output logic [COUNT_WIDTH-1:0]         step_index,
  output logic                           halted,
  output logic [2:0]                     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EXEC       = 3'd1,
    S_IO_WAIT    = 3'd2,
    S_IO_RELEASE = 3'd3,
    S_BURST      = 3'd4,
    S_HALTED     = 3'd5
  } state_t;

  localparam int CH_W  = $clog2(IO_CHANNELS);
  // Buttons are handled uniformly: indices 0..IO_CHANNELS-1 are the confirm
  // buttons, index IO_CHANNELS is the PAUSE continue button.
  localparam int NB    = IO_CHANNELS + 1;
  localparam int SEL_W = $clog2(NB);

  localparam logic [ID_WIDTH-1:0]    ID_OUTPUT = ID_WIDTH'(69);
  localparam logic [ID_WIDTH-1:0]    ID_PAUSE  = ID_WIDTH'(70);
  localparam logic [ID_WIDTH-1:0]    ID_INPUT  = ID_WIDTH'(71);
  localparam logic [ID_WIDTH-1:0]    ID_HALT   = ID_WIDTH'(75);
  localparam logic [ID_WIDTH-1:0]    ID_PUSHN  = ID_WIDTH'(77);
  localparam logic [ID_WIDTH-1:0]    ID_POPN   = ID_WIDTH'(78);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [SEL_W-1:0]       SEL_CONT  = SEL_W'(IO_CHANNELS);

  // ---------------------------------------------------------------------
  // Button synchronizers
  // ---------------------------------------------------------------------
  logic [NB-1:0]                   btn_raw;
  logic [SYNC_STAGES-1:0][NB-1:0]  sync_q, sync_d;
  logic [NB-1:0]                   btn_level;
  logic [NB-1:0]                   btn_rise;

  assign btn_raw = {continue_button, confirmation};

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = btn_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Edge taken between the last two stages; the last stage is the level.
  assign btn_level = sync_q[SYNC_STAGES-1];
  assign btn_rise  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ---------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   step_q, step_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [NB-1:0]            armed_q, armed_d;
  logic                     enable_q, enable_d;
  logic                     busy_q, busy_d;
  logic                     is_input_q, is_input_d;
  logic                     is_output_q, is_output_d;
  logic [IO_CHANNELS-1:0]   io_select_q, io_select_d;
  logic                     mem_write_q, mem_write_d;
  logic                     mem_read_q, mem_read_d;
  logic                     halted_q, halted_d;

  logic [CH_W-1:0]          ch_eff;
  logic [COUNT_WIDTH-1:0]   last_step;
  logic                     id_is_io;
  logic                     id_is_burst;

  always_comb begin
    if ({1'b0, io_channel} >= (CH_W+1)'(IO_CHANNELS)) begin
      ch_eff = '0;
    end else begin
      ch_eff = io_channel;
    end
  end

  assign id_is_io    = (ID == ID_OUTPUT) || (ID == ID_INPUT) || (ID == ID_PAUSE);
  assign id_is_burst = (ID == ID_PUSHN) || (ID == ID_POPN);
  // Only meaningful in BURST, where cnt_q is at least 1.
  assign last_step   = cnt_q - CNT_ONE;

  // Registered outputs are computed for the state being entered, so each
  // output is valid in the same cycle as the state it describes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    armed_d     = armed_q;
    step_d      = '0;
    enable_d    = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    busy_d      = busy_q;
    is_input_d  = is_input_q;
    is_output_d = is_output_q;
    io_select_d = io_select_q;
    halted_d    = halted_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          cnt_d  = operand_count;
          sel_d  = (ID == ID_PAUSE) ? SEL_CONT : SEL_W'(ch_eff);
          busy_d = 1'b1;
          if (id_is_io) begin
            state_d     = S_IO_WAIT;
            is_output_d = (ID == ID_OUTPUT) || (ID == ID_PAUSE);
            is_input_d  = (ID == ID_INPUT)  || (ID == ID_PAUSE);
            io_select_d = '0;
            if (ID != ID_PAUSE) begin
              io_select_d[ch_eff] = 1'b1;
            end
          end else if (id_is_burst && (operand_count != '0)) begin
            state_d     = S_BURST;
            mem_write_d = (ID == ID_PUSHN);
            mem_read_d  = (ID == ID_POPN);
            enable_d    = (operand_count == CNT_ONE);
          end else if (ID == ID_HALT) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = S_EXEC;
            enable_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      S_IO_WAIT: begin
        if (btn_rise[sel_q] && armed_q[sel_q]) begin
          state_d        = S_IO_RELEASE;
          enable_d       = 1'b1;
          armed_d[sel_q] = 1'b0;
          is_input_d     = 1'b0;
          is_output_d    = 1'b0;
          io_select_d    = '0;
        end
      end

      // A held button keeps us here, so it cannot complete a second I/O.
      S_IO_RELEASE: begin
        if (!btn_level[sel_q]) begin
          state_d        = S_IDLE;
          armed_d[sel_q] = 1'b1;
          busy_d         = 1'b0;
        end
      end

      S_BURST: begin
        if (step_q == last_step) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          step_d      = step_q + CNT_ONE;
          mem_write_d = mem_write_q;
          mem_read_d  = mem_read_q;
          enable_d    = ((step_q + CNT_ONE) == last_step);
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      sel_q       <= '0;
      armed_q     <= '1;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      is_input_q  <= 1'b0;
      is_output_q <= 1'b0;
      io_select_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      sel_q       <= sel_d;
      armed_q     <= armed_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      is_input_q  <= is_input_d;
      is_output_q <= is_output_d;
      io_select_q <= io_select_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      halted_q    <= halted_d;
    end
  end

  assign enable     = enable_q;
  assign busy       = busy_q;
  assign is_input   = is_input_q;
  assign is_output  = is_output_q;
  assign io_select  = io_select_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign step_index = step_q;
  assign halted     = halted_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios followed by randomized
// instruction mixes. A monitor pops expected completion/strobe words from a
// queue whenever the DUT shows enable, mem_write or mem_read.
module tb_control_sequencer;

  localparam int ID_WIDTH    = 7;
  localparam int COUNT_WIDTH = 5;
  localparam int IO_CHANNELS = 2;
  localparam int SYNC_STAGES = 2;
  localparam int EW          = 3 + COUNT_WIDTH;
  localparam logic [EW-1:0] IO_DONE = {1'b1, 2'b00, {COUNT_WIDTH{1'b0}}};

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                   instr_valid = 1'b0;
  logic [ID_WIDTH-1:0]    id_in = '0;
  logic [COUNT_WIDTH-1:0] operand_count = '0;
  logic [0:0]             io_channel = '0;
  logic [IO_CHANNELS-1:0] confirmation = '0;
  logic                   continue_button = 1'b0;
  logic                   enable, busy, is_input, is_output;
  logic [IO_CHANNELS-1:0] io_select;
  logic                   mem_write, mem_read, halted;
  logic [COUNT_WIDTH-1:0] step_index;
  logic [2:0]             state_dbg;

  control_sequencer #(
    .ID_WIDTH(ID_WIDTH), .COUNT_WIDTH(COUNT_WIDTH),
    .IO_CHANNELS(IO_CHANNELS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .ID(id_in),
    .operand_count(operand_count), .io_channel(io_channel),
    .confirmation(confirmation), .continue_button(continue_button),
    .enable(enable), .busy(busy), .is_input(is_input), .is_output(is_output),
    .io_select(io_select), .mem_write(mem_write), .mem_read(mem_read),
    .step_index(step_index), .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [13:0] all_outputs();
    return {enable, busy, is_input, is_output, io_select, mem_write, mem_read,
            step_index, halted};
  endfunction

  // Reference: what one beat of an instruction looks like on
  // {enable, mem_write, mem_read, step_index}.
  function automatic logic [EW-1:0] beat_word(input int op, input int cnt, input int k);
    logic                   l, w, r;
    logic [COUNT_WIDTH-1:0] s;
    if ((op == 77 || op == 78) && cnt > 0) begin
      l = (k == cnt - 1);
      w = (op == 77);
      r = (op == 78);
      s = COUNT_WIDTH'(k);
      return {l, w, r, s};
    end
    return IO_DONE;
  endfunction

  function automatic int beats_of(input int op, input int cnt);
    if (op == 75 || op == 69 || op == 70 || op == 71) return 0;
    if ((op == 77 || op == 78) && cnt > 0) return cnt;
    return 1;
  endfunction

  // I/O completions are pushed when the bench presses the right button.
  function automatic void model_push(input int op, input int cnt);
    for (int k = 0; k < beats_of(op, cnt); k++) exp_q.push_back(beat_word(op, cnt, k));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset === 1'b0 && (enable === 1'b1 || mem_write === 1'b1 || mem_read === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none t=%0t",
                 {enable, mem_write, mem_read, step_index}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event", {enable, mem_write, mem_read, step_index}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(name, busy, 0);
  endtask

  // Returns at the first negedge after acceptance.
  task automatic issue(input int op, input int cnt, input int ch);
    wait_idle("idle_before_issue");
    model_push(op, cnt);
    @(negedge clock);
    id_in         = ID_WIDTH'(op);
    operand_count = COUNT_WIDTH'(cnt);
    io_channel    = 1'(ch);
    instr_valid   = 1'b1;
    @(negedge clock);
    instr_valid   = 1'b0;
    id_in         = ID_WIDTH'($urandom_range(0, 127));
    check("busy_after_issue", busy, 1);
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b < IO_CHANNELS) confirmation[b] = v;
    else continue_button = v;
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (enable !== 1'b1 && n < SYNC_STAGES + 4);
    check(name, (enable === 1'b1) && (n >= SYNC_STAGES) && (n <= SYNC_STAGES + 1), 1);
  endtask

  // EXEC-style and burst instructions, checked beat by beat.
  task automatic run_simple(input int op, input int cnt);
    int nb;
    nb = beats_of(op, cnt);
    issue(op, cnt, 0);
    for (int k = 0; k < nb; k++) begin
      check("beat", {enable, mem_write, mem_read, step_index}, beat_word(op, cnt, k));
      @(negedge clock);
    end
    check("done_idle", {busy, enable, mem_write, mem_read, step_index}, 0);
  endtask

  task automatic run_io(input int op, input int ch);
    int btn, noise;
    logic [IO_CHANNELS-1:0] sel_e;
    btn   = (op == 70) ? IO_CHANNELS : ch;
    sel_e = (op == 70) ? '0 : IO_CHANNELS'(1 << ch);
    issue(op, 0, ch);
    check("io_flags", {is_input, is_output, io_select},
          {(op == 71 || op == 70), (op == 69 || op == 70), sel_e});
    noise = (btn + $urandom_range(1, IO_CHANNELS)) % (IO_CHANNELS + 1);
    set_btn(noise, 1'b1);
    repeat ($urandom_range(1, 4)) @(negedge clock);
    set_btn(noise, 1'b0);
    repeat (5) @(negedge clock);
    check("io_still_waiting", {busy, is_input | is_output}, 2'b11);
    exp_q.push_back(IO_DONE);
    set_btn(btn, 1'b1);
    wait_enable("io_latency");
    check("io_flags_drop", {is_input, is_output, io_select}, 0);
    repeat ($urandom_range(1, 5)) @(negedge clock);
    set_btn(btn, 1'b0);
    wait_idle("io_release_idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, op, cnt;
    #12;
    check("reset_outputs", all_outputs(), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_outputs", all_outputs(), 0);

    // single-cycle instruction: enable next cycle, busy drops after
    issue(4, 0, 0);
    check("exec_enable", {enable, busy}, 2'b11);
    @(negedge clock);
    check("exec_busy_low", {enable, busy}, 2'b00);

    run_simple(77, 3);
    run_simple(78, 0);
    run_simple(78, 1);
    run_simple(77, 31);

    // INPUT on channel 1 ignores channel 0
    issue(71, 0, 1);
    check("in_flags", {is_input, is_output, io_select}, 4'b1010);
    set_btn(0, 1'b1);
    repeat (3) @(negedge clock);
    set_btn(0, 1'b0);
    repeat (6) @(negedge clock);
    check("in_wrong_channel", {busy, is_input}, 2'b11);
    exp_q.push_back(IO_DONE);
    set_btn(1, 1'b1);
    wait_enable("in_latency");
    check("in_drop", is_input, 0);
    set_btn(1, 1'b0);
    wait_idle("in_idle");

    // OUTPUT with a held button
    issue(69, 0, 0);
    exp_q.push_back(IO_DONE);
    set_btn(0, 1'b1);
    wait_enable("out1_latency");
    repeat (10) @(negedge clock);
    check("out1_held_release", {busy, is_output}, 2'b10);
    set_btn(0, 1'b0);
    wait_idle("out1_idle");
    set_btn(0, 1'b1);
    repeat (4) @(negedge clock);
    issue(69, 0, 0);
    repeat (10) @(negedge clock);
    check("out2_held_no_complete", {busy, is_output}, 2'b11);
    set_btn(0, 1'b0);
    repeat (4) @(negedge clock);
    exp_q.push_back(IO_DONE);
    set_btn(0, 1'b1);
    wait_enable("out2_latency");
    set_btn(0, 1'b0);
    wait_idle("out2_idle");

    run_io(70, 0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do op = $urandom_range(0, 127);
        while (op == 69 || op == 70 || op == 71 || op == 75 || op == 77 || op == 78);
        run_simple(op, $urandom_range(0, 31));
      end else if (r < 5) begin
        op = ($urandom_range(0, 1) == 0) ? 77 : 78;
        case ($urandom_range(0, 3))
          0: cnt = 0;
          1: cnt = 1;
          2: cnt = $urandom_range(2, 8);
          default: cnt = 31;
        endcase
        run_simple(op, cnt);
      end else begin
        op = $urandom_range(69, 71);
        run_io(op, $urandom_range(0, IO_CHANNELS - 1));
      end
    end

    // reset in the middle of a burst
    issue(77, 8, 0);
    for (int k = 0; k <= 4; k++) begin
      check("abort_beat", {enable, mem_write, mem_read, step_index}, beat_word(77, 8, k));
      if (k < 4) @(negedge clock);
    end
    #2 reset = 1'b1;
    #1 check("abort_outputs", all_outputs(), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle", all_outputs(), 0);
    run_simple(4, 0);

    // HALT ignores further instructions until reset
    issue(75, 0, 0);
    check("halted", {halted, busy, enable}, 3'b110);
    id_in = ID_WIDTH'(4);
    instr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("halt_hold", {halted, busy, enable}, 3'b110);
    end
    instr_valid = 1'b0;
    #3 reset = 1'b1;
    #1 check("halt_async_reset", all_outputs(), 0);
    @(negedge clock);
    reset = 1'b0;
    run_simple(4, 0);

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
